// File: rtl/rv32i_mem_arb.sv
// Arbitrates the rv32i instruction and data ports onto one single-port synchronous RAM.
// Stores issue in one cycle; reads wait RAM_LAT cycles and the result is held per port.
module rv32i_mem_arb #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_i_addr,
    input  logic              mem_i_rstrb,
    output logic [31:0]       mem_i_rdata,
    output logic              mem_i_rbusy,
    input  logic [31:0]       mem_d_addr,
    input  logic [31:0]       mem_d_wdata,
    input  logic [3:0]        mem_d_wmask,
    input  logic              mem_d_wstrb,
    input  logic              mem_d_rstrb,
    output logic [31:0]       mem_d_rdata,
    output logic              mem_d_rbusy,
    output logic              mem_d_wbusy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_wmask,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    state_t     state;
    logic [2:0] cnt;

    logic idle;
    logic issue_w;
    logic issue_dr;
    logic issue_ir;
    logic done_i;
    logic done_d;

    always_comb begin
        idle     = (state == IDLE);
        issue_w  = idle && mem_d_wstrb;
        issue_dr = idle && !mem_d_wstrb && mem_d_rstrb;
        issue_ir = idle && !mem_d_wstrb && !mem_d_rstrb && mem_i_rstrb;
        done_i   = (state == RD_I) && (cnt == 3'd1);
        done_d   = (state == RD_D) && (cnt == 3'd1);
    end

    // A strobe that is high but not completing this cycle reports busy.
    always_comb begin
        mem_d_wbusy = !rst && mem_d_wstrb && !issue_w;
        mem_d_rbusy = !rst && mem_d_rstrb && !done_d;
        mem_i_rbusy = !rst && mem_i_rstrb && !done_i;
        ram_en      = !rst && (issue_w || issue_dr || issue_ir);
        ram_we      = !rst && issue_w;
        ram_addr    = issue_ir ? mem_i_addr[ADDR_W+1:2] : mem_d_addr[ADDR_W+1:2];
        ram_wmask   = mem_d_wmask;
        ram_wdata   = mem_d_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            mem_i_rdata <= 32'd0;
            mem_d_rdata <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (issue_dr) begin
                        state <= RD_D;
                        cnt   <= LAT;
                    end else if (issue_ir) begin
                        state <= RD_I;
                        cnt   <= LAT;
                    end
                end
                RD_I, RD_D: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= IDLE;
                        if (state == RD_I) mem_i_rdata <= ram_rdata;
                        else               mem_d_rdata <= ram_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-offset and above-window address bits are intentionally dropped (addresses wrap).
    logic unused_bits;
    assign unused_bits = ^{mem_i_addr[31:ADDR_W+2], mem_i_addr[1:0],
                           mem_d_addr[31:ADDR_W+2], mem_d_addr[1:0]};

endmodule

// File: tb/tb_rv32i_mem_arb.sv
// Self-checking bench: a RAM_LAT=1 instance runs the vector table and port-conflict
// sequences, a RAM_LAT=3 instance covers long-latency reads and reset mid-read.
module tb_rv32i_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        i_rstrb = 0, d_rstrb = 0, d_wstrb = 0;
    logic        i_rstrb3 = 0, d_rstrb3 = 0, d_wstrb3 = 0;

    logic [31:0] i_rdata1, d_rdata1, ram_wdata1, ram_rdata1;
    logic        i_rbusy1, d_rbusy1, d_wbusy1, ram_en1, ram_we1;
    logic [11:0] ram_addr1;
    logic [3:0]  ram_wmask1;
    logic [31:0] i_rdata3, d_rdata3, ram_wdata3, ram_rdata3;
    logic        i_rbusy3, d_rbusy3, d_wbusy3, ram_en3, ram_we3;
    logic [11:0] ram_addr3;
    logic [3:0]  ram_wmask3;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rv32i_mem_arb #(.ADDR_W(12), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_i_addr(i_addr), .mem_i_rstrb(i_rstrb), .mem_i_rdata(i_rdata1), .mem_i_rbusy(i_rbusy1),
        .mem_d_addr(d_addr), .mem_d_wdata(d_wdata), .mem_d_wmask(d_wmask),
        .mem_d_wstrb(d_wstrb), .mem_d_rstrb(d_rstrb), .mem_d_rdata(d_rdata1),
        .mem_d_rbusy(d_rbusy1), .mem_d_wbusy(d_wbusy1),
        .ram_addr(ram_addr1), .ram_en(ram_en1), .ram_we(ram_we1), .ram_wmask(ram_wmask1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    rv32i_mem_arb #(.ADDR_W(12), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .mem_i_addr(i_addr), .mem_i_rstrb(i_rstrb3), .mem_i_rdata(i_rdata3), .mem_i_rbusy(i_rbusy3),
        .mem_d_addr(d_addr), .mem_d_wdata(d_wdata), .mem_d_wmask(d_wmask),
        .mem_d_wstrb(d_wstrb3), .mem_d_rstrb(d_rstrb3), .mem_d_rdata(d_rdata3),
        .mem_d_rbusy(d_rbusy3), .mem_d_wbusy(d_wbusy3),
        .ram_addr(ram_addr3), .ram_en(ram_en3), .ram_we(ram_we3), .ram_wmask(ram_wmask3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
    );

    // RAM models; outputs carry a poison value when no read is due.
    bit [31:0]   mem1 [4096];
    bit [31:0]   mem3 [4096];
    logic [31:0] p0 = '0, p1 = '0, p2 = '0;

    always @(posedge clk) begin
        if (ram_en1 && ram_we1)
            for (int b = 0; b < 4; b++)
                if (ram_wmask1[b]) mem1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
        ram_rdata1 <= (ram_en1 && !ram_we1) ? mem1[ram_addr1] : 32'hDEADBEEF;
        if (ram_en3 && ram_we3)
            for (int b = 0; b < 4; b++)
                if (ram_wmask3[b]) mem3[ram_addr3][8*b +: 8] <= ram_wdata3[8*b +: 8];
        p0 <= (ram_en3 && !ram_we3) ? mem3[ram_addr3] : 32'hDEADBEEF;
        p1 <= p0;
        p2 <= p1;
    end
    assign ram_rdata3 = p2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          op;        // 0 store, 1 load, 2 fetch
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_data;
        logic [11:0] exp_raddr;
        string       name;
    } vec_t;

    // Single transaction on the RAM_LAT=1 instance.
    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        if (v.op == 0) begin
            d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask; d_wstrb = 1;
            @(negedge clk);
            chk({v.name, "_en"}, 32'(ram_en1), 32'd1);
            chk({v.name, "_we"}, 32'(ram_we1), 32'd1);
            chk({v.name, "_wbusy"}, 32'(d_wbusy1), 32'd0);
            chk({v.name, "_raddr"}, 32'(ram_addr1), 32'(v.exp_raddr));
            chk({v.name, "_wmask"}, 32'(ram_wmask1), 32'(v.wmask));
            @(posedge clk); #1;
            d_wstrb = 0;
        end else begin
            if (v.op == 1) begin d_addr = v.addr; d_rstrb = 1; end
            else           begin i_addr = v.addr; i_rstrb = 1; end
            @(negedge clk);
            chk({v.name, "_en"}, 32'(ram_en1 && !ram_we1), 32'd1);
            chk({v.name, "_raddr"}, 32'(ram_addr1), 32'(v.exp_raddr));
            chk({v.name, "_busy0"}, 32'(v.op == 1 ? d_rbusy1 : i_rbusy1), 32'd1);
            @(negedge clk);
            chk({v.name, "_busy1"}, 32'(v.op == 1 ? d_rbusy1 : i_rbusy1), 32'd0);
            chk({v.name, "_en_done"}, 32'(ram_en1), 32'd0);
            @(posedge clk); #1;
            d_rstrb = 0; i_rstrb = 0;
            @(negedge clk);
            chk({v.name, "_rdata"}, v.op == 1 ? d_rdata1 : i_rdata1, v.exp_data);
        end
    endtask

    // Read on the RAM_LAT=3 instance, counting busy cycles and RAM enables.
    task automatic lat3_read(input bit is_i, input logic [31:0] addr, input logic [31:0] exp,
                             input string nm);
        int  busy_n = 0;
        int  en_n = 0;
        bit  done = 0;
        @(posedge clk); #1;
        if (is_i) begin i_addr = addr; i_rstrb3 = 1; end
        else      begin d_addr = addr; d_rstrb3 = 1; end
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            if (ram_en3) en_n++;
            if (is_i ? i_rbusy3 : d_rbusy3) busy_n++;
            else done = 1;
            @(posedge clk); #1;
        end
        i_rstrb3 = 0; d_rstrb3 = 0;
        chk({nm, "_completed"}, 32'(done), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd3);
        chk({nm, "_en_pulses"}, 32'(en_n), 32'd1);
        @(negedge clk);
        chk({nm, "_rdata"}, is_i ? i_rdata3 : d_rdata3, exp);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 32'h10,       32'h00000013, 4'hF, 32'h0,        12'h004, "st_w4"};
        vecs[1]  = '{2, 32'h10,       32'h0,        4'h0, 32'h00000013, 12'h004, "t1_fetch"};
        vecs[2]  = '{0, 32'h22,       32'hAABBCCDD, 4'h4, 32'h0,        12'h008, "t2_store"};
        vecs[3]  = '{1, 32'h20,       32'h0,        4'h0, 32'h00BB0000, 12'h008, "t2_load"};
        vecs[4]  = '{0, 32'h3FFC,     32'h12345678, 4'hF, 32'h0,        12'hFFF, "t6_store"};
        vecs[5]  = '{2, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h12345678, 12'hFFF, "t6_wrap"};
        vecs[6]  = '{0, 32'h100,      32'hCAFEF00D, 4'hF, 32'h0,        12'h040, "st_full"};
        vecs[7]  = '{0, 32'h100,      32'h11111111, 4'h1, 32'h0,        12'h040, "st_byte0"};
        vecs[8]  = '{1, 32'h102,      32'h0,        4'h0, 32'hCAFEF011, 12'h040, "ld_merge"};
        vecs[9]  = '{0, 32'h40,       32'hD0D0D0D0, 4'hF, 32'h0,        12'h010, "st_w16"};
        vecs[10] = '{0, 32'h80,       32'h1A1A1A1A, 4'hF, 32'h0,        12'h020, "st_w32"};

        // Reset state, with every strobe forced high.
        #2;
        i_rstrb = 1; d_rstrb = 1; d_wstrb = 1;
        @(negedge clk);
        chk("rst_en", 32'(ram_en1), 32'd0);
        chk("rst_we", 32'(ram_we1), 32'd0);
        chk("rst_busy", {29'd0, i_rbusy1, d_rbusy1, d_wbusy1}, 32'd0);
        chk("rst_i_rdata", i_rdata1, 32'd0);
        chk("rst_d_rdata", d_rdata1, 32'd0);
        i_rstrb = 0; d_rstrb = 0; d_wstrb = 0;
        @(posedge clk); #1;
        rst = 0;

        foreach (vecs[n]) run_vec(vecs[n]);

        // T3: simultaneous fetch and load; the load wins, the fetch waits.
        @(posedge clk); #1;
        d_addr = 32'h40; i_addr = 32'h80; d_rstrb = 1; i_rstrb = 1;
        @(negedge clk);
        chk("t3_c0_raddr", 32'(ram_addr1), 32'h010);
        chk("t3_c0_busy", {30'd0, d_rbusy1, i_rbusy1}, 32'b11);
        @(negedge clk);
        chk("t3_c1_busy", {30'd0, d_rbusy1, i_rbusy1}, 32'b01);
        chk("t3_c1_en", 32'(ram_en1), 32'd0);
        @(posedge clk); #1;
        d_rstrb = 0;
        @(negedge clk);
        chk("t3_c2_en", 32'(ram_en1), 32'd1);
        chk("t3_c2_raddr", 32'(ram_addr1), 32'h020);
        chk("t3_c2_i_busy", 32'(i_rbusy1), 32'd1);
        chk("t3_d_rdata", d_rdata1, 32'hD0D0D0D0);
        @(negedge clk);
        chk("t3_c3_i_busy", 32'(i_rbusy1), 32'd0);
        @(posedge clk); #1;
        i_rstrb = 0;
        @(negedge clk);
        chk("t3_i_rdata", i_rdata1, 32'h1A1A1A1A);

        // Store and load together on the data port: write first, then read the new word.
        @(posedge clk); #1;
        d_addr = 32'h200; d_wdata = 32'h5555AAAA; d_wmask = 4'hF; d_wstrb = 1; d_rstrb = 1;
        @(negedge clk);
        chk("wr_c0_we", {30'd0, ram_en1, ram_we1}, 32'b11);
        chk("wr_c0_busy", {30'd0, d_wbusy1, d_rbusy1}, 32'b01);
        @(posedge clk); #1;
        d_wstrb = 0;
        @(negedge clk);
        chk("wr_c1_rd", {30'd0, ram_en1, ram_we1}, 32'b10);
        chk("wr_c1_rbusy", 32'(d_rbusy1), 32'd1);
        @(negedge clk);
        chk("wr_c2_rbusy", 32'(d_rbusy1), 32'd0);
        @(posedge clk); #1;
        d_rstrb = 0;
        @(negedge clk);
        chk("wr_rdata", d_rdata1, 32'h5555AAAA);

        // Preload the RAM_LAT=3 instance.
        @(posedge clk); #1;
        d_addr = 32'h40; d_wdata = 32'h33333333; d_wmask = 4'hF; d_wstrb3 = 1;
        @(posedge clk); #1;
        d_addr = 32'h10; d_wdata = 32'h00000013;
        @(posedge clk); #1;
        d_wstrb3 = 0;

        // T4
        lat3_read(1'b0, 32'h40, 32'h33333333, "t4_lat3");

        // T5: asynchronous reset while the fetch is in RD_I.
        @(posedge clk); #1;
        i_addr = 32'h10; i_rstrb3 = 1;
        @(negedge clk);
        chk("t5_busy_pre", 32'(i_rbusy3), 32'd1);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("t5_busy_rst", 32'(i_rbusy3), 32'd0);
        chk("t5_en_rst", 32'(ram_en3), 32'd0);
        chk("t5_i_rdata_rst", i_rdata3, 32'd0);
        chk("t5_d_rdata_rst", d_rdata3, 32'd0);
        @(posedge clk); #1;
        i_rstrb3 = 0;
        @(posedge clk); #1;
        rst = 0;
        lat3_read(1'b1, 32'h10, 32'h00000013, "t5_refetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
